hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Decode-stage hazard controller for the five-stage MIPS pipeline: detects dependencies that operand forwarding cannot cover and holds the PC and IF/ID register while inserting bubbles into ID/EX. It handles load-use and `jr`-source dependencies, and squashes the wrong-path instructions on a taken branch resolved in EX. It sits beside the forwarding control. It consumes the same ID/EX/MEM register-number and write-enable signals, and drives the pipeline-register enables and flushes.

## Interface
- STAT_W, 32, width of the optional statistics counters
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- Rs, Rt  in  5 each  source register numbers of the instruction in ID
- UseRt  in  1  instruction in ID reads Rt as an operand
- PCSrc  in  3  PC source of the instruction in ID; 3'b011 = jr
- RegWrite_ex, MemRead_ex  in  1 each  write-back enable and load flag of the instruction in EX
- Write_register  in  5  destination register of the instruction in EX
- RegWrite_mem  in  1  write-back enable of the instruction in MEM
- Write_register_mem  in  5  destination register of the instruction in MEM
- BranchTaken_ex  in  1  branch resolved taken in EX
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID register enable
- IFIDFlush  out  1  zero the IF/ID register
- IDEXFlush  out  1  load a bubble (all control bits 0) into ID/EX
- StallCycles, FlushCount  out  STAT_W each  present only under HAZARD_STATS_EN

## Operation
- FSM states are RUN, HOLD2 and HOLD1. The state register resets asynchronously to RUN.
- Hazard conditions are evaluated in RUN only:
  - LU (load-use): MemRead_ex, Write_register≠0, and Write_register==Rs or (UseRt and Write_register==Rt). Need = 1.
  - JL (jr on a load in EX): PCSrc==011, MemRead_ex, Write_register≠0, Write_register==Rs. Need = 2.
  - JM (jr on any write in MEM): PCSrc==011, RegWrite_mem, Write_register_mem≠0, Write_register_mem==Rs. Need = 1.
  - A non-load jr dependency in EX is not a hazard, because the forwarding path covers it.
- Need is the maximum over the active conditions.
- Stall cycle outputs: PCWrite=0, IFIDWrite=0, IDEXFlush=1, IFIDFlush=0.
- RUN transitions:
  - Need 0: all enables 1, both flushes 0, stay in RUN.
  - Need 1: stall cycle, stay in RUN. The condition has cleared next cycle because the bubble advanced.
  - Need 2: stall cycle, go to HOLD1.
- HOLD1: stall cycle, return to RUN. HOLD2 is reserved for a future 3-cycle need and behaves as stall, then HOLD1.
- Branch flush: BranchTaken_ex=1 forces PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXFlush=1, and the next state is RUN. It overrides any hazard and aborts HOLD1/HOLD2, because the stalled instruction is on the wrong path.
- Reset outputs: while reset is low, PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXFlush=1.

## Timing
- Hazard outputs are combinational from the ID/EX/MEM inputs and the state, valid in the same cycle the hazard is presented.
- State updates on the rising edge of clk.
- Load-use penalty is 1 cycle, jr-on-EX-load is 2 cycles, jr-on-MEM-write is 1 cycle.
- Back-to-back hazards: re-evaluation happens on the first RUN cycle after a hold, so an instruction with a new dependency stalls again.
- Reset asserted mid-hold returns to RUN at once. After release, the first edge resumes normal operation.
- The branch flush is a single cycle and adds no extra latency.

## Configuration
- HAZARD_STATS_EN defined:
  - StallCycles increments on every stall cycle.
  - FlushCount increments on every branch-flush cycle.
  - Both counters saturate at all-ones and reset asynchronously to 0.
- HAZARD_STATS_EN undefined: the counters and both ports are absent. Stall and flush behaviour is identical.

## Structure
- Shared package hazard_pkg holds:
  - state encoding (RUN=2'd0, HOLD1=2'd1, HOLD2=2'd2)
  - PCSRC_JR=3'b011
  - STAT_W default
- Sub-module hazard_stat_counter is a saturating counter with enable. It is instantiated twice under HAZARD_STATS_EN.

## Test plan
- Load to $t0 in EX, add $t1,$t0,$t2 in ID (Rs=8) -> 1 cycle with PCWrite=0, IDEXFlush=1, then RUN with all enables 1.
- Load to $t0 in EX, jr $t0 in ID -> 2 stall cycles (RUN→HOLD1→RUN), PCWrite=1 on cycle 3.
- addi $ra in EX, jr $ra in ID -> no stall. Same add in MEM instead -> 1 stall.
- Load to $0 in EX, reader of $0 in ID -> no stall.
- BranchTaken_ex=1 during HOLD1 -> IFIDFlush=IDEXFlush=1, PCWrite=1, next state RUN.
- HAZARD_STATS_EN: 3 stalls plus 1 flush -> StallCycles=3, FlushCount=1. Reset low mid-hold -> counters 0, outputs at their reset values.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the decode-stage hazard controller.
// Holds the FSM state encoding, the jr PC-source code and the default
// width of the optional statistics counters.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD1 = 2'd1,
        HOLD2 = 2'd2
    } hazard_state_t;

    localparam logic [2:0] PCSRC_JR       = 3'b011;
    localparam int         STAT_W_DEFAULT = 32;

endpackage

// File: rtl/hazard_stat_counter.sv
// hazard_stat_counter: saturating event counter with enable.
// Sticks at all-ones so a long run never wraps back to a small value.
module hazard_stat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count enabled cycles, hold at all-ones, clear on async reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: decode-stage hazard controller for the 5-stage pipeline.
// Stalls PC and IF/ID while bubbling ID/EX on load-use and jr-source
// dependencies that forwarding cannot cover; squashes the wrong path on a
// taken branch resolved in EX.
// Optional feature macro: HAZARD_STATS_EN adds StallCycles / FlushCount.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  RUN   | evaluate hazards; stall once for need 1, go to HOLD1 for need 2
//  HOLD1 | last stall cycle of a multi-cycle hold, then RUN
//  HOLD2 | reserved for a 3-cycle need: stall, then HOLD1
import hazard_pkg::*;

module hazard_stall_unit #(
    parameter int STAT_W = STAT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        Rs,
    input  logic [4:0]        Rt,
    input  logic              UseRt,
    input  logic [2:0]        PCSrc,
    input  logic              RegWrite_ex,
    input  logic              MemRead_ex,
    input  logic [4:0]        Write_register,
    input  logic              RegWrite_mem,
    input  logic [4:0]        Write_register_mem,
    input  logic              BranchTaken_ex,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic              IFIDFlush,
`ifdef HAZARD_STATS_EN
    output logic              IDEXFlush,
    output logic [STAT_W-1:0] StallCycles,
    output logic [STAT_W-1:0] FlushCount
`else
    output logic              IDEXFlush
`endif
);

    hazard_state_t state, state_nxt;
    logic          is_jr;
    logic          haz_lu, haz_jl, haz_jm;
    logic [1:0]    need;
    logic          unused_ok;

    // RegWrite_ex only matters to forwarding: a non-load jr source in EX is covered there.
    assign unused_ok = RegWrite_ex;

    assign is_jr  = (PCSrc == PCSRC_JR);
    assign haz_lu = MemRead_ex && (Write_register != 5'd0) &&
                    ((Write_register == Rs) || (UseRt && (Write_register == Rt)));
    assign haz_jl = is_jr && MemRead_ex && (Write_register != 5'd0) &&
                    (Write_register == Rs);
    assign haz_jm = is_jr && RegWrite_mem && (Write_register_mem != 5'd0) &&
                    (Write_register_mem == Rs);
    assign need   = haz_jl ? 2'd2 : ((haz_lu || haz_jm) ? 2'd1 : 2'd0);

    // State register, forced to RUN asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and pipeline-register controls; branch flush beats hazards, reset beats all.
    always_comb begin
        state_nxt = state;
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b0;
        IDEXFlush = 1'b0;
        if (BranchTaken_ex) begin
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
            state_nxt = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (need != 2'd0) begin
                        PCWrite   = 1'b0;
                        IFIDWrite = 1'b0;
                        IDEXFlush = 1'b1;
                    end
                    if (need == 2'd2) begin
                        state_nxt = HOLD1;
                    end
                end
                HOLD1: begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    IDEXFlush = 1'b1;
                    state_nxt = RUN;
                end
                HOLD2: begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    IDEXFlush = 1'b1;
                    state_nxt = HOLD1;
                end
                default: state_nxt = RUN;
            endcase
        end
        if (!reset) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
            state_nxt = RUN;
        end
    end

`ifdef HAZARD_STATS_EN
    logic stall_en, flush_en;

    // A stall cycle holds PC without a flush of IF/ID; a branch flush always sets IFIDFlush.
    assign stall_en = reset && !PCWrite && !IFIDFlush;
    assign flush_en = reset && IFIDFlush;

    hazard_stat_counter #(.W(STAT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall_en),
        .count (StallCycles)
    );

    hazard_stat_counter #(.W(STAT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (flush_en),
        .count (FlushCount)
    );
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: scoreboard bench for hazard_stall_unit.
// Build with HAZARD_STATS_EN defined to also exercise the counters.
module tb_hazard_stall_unit;

    localparam int STAT_W = 32;

    // Expected {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush}
    localparam logic [3:0] E_RUN   = 4'b1100;
    localparam logic [3:0] E_STALL = 4'b0001;
    localparam logic [3:0] E_FLUSH = 4'b1111;
    localparam logic [3:0] E_RST   = 4'b0011;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rt;
        logic [2:0] pcsrc;
        logic       rw_ex;
        logic       mr_ex;
        logic [4:0] wr_ex;
        logic       rw_mem;
        logic [4:0] wr_mem;
        logic       br;
    } stim_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs, Rt, Write_register, Write_register_mem;
    logic       UseRt, RegWrite_ex, MemRead_ex, RegWrite_mem, BranchTaken_ex;
    logic [2:0] PCSrc;
    logic       PCWrite, IFIDWrite, IFIDFlush, IDEXFlush;
`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] StallCycles, FlushCount;
`endif

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    hazard_stall_unit #(.STAT_W(STAT_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .Rs                 (Rs),
        .Rt                 (Rt),
        .UseRt              (UseRt),
        .PCSrc              (PCSrc),
        .RegWrite_ex        (RegWrite_ex),
        .MemRead_ex         (MemRead_ex),
        .Write_register     (Write_register),
        .RegWrite_mem       (RegWrite_mem),
        .Write_register_mem (Write_register_mem),
        .BranchTaken_ex     (BranchTaken_ex),
        .PCWrite            (PCWrite),
        .IFIDWrite          (IFIDWrite),
        .IFIDFlush          (IFIDFlush),
`ifdef HAZARD_STATS_EN
        .IDEXFlush          (IDEXFlush),
        .StallCycles        (StallCycles),
        .FlushCount         (FlushCount)
`else
        .IDEXFlush          (IDEXFlush)
`endif
    );

    function automatic stim_t st(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                                 input logic [2:0] pcsrc, input logic rw_ex, input logic mr_ex,
                                 input logic [4:0] wr_ex, input logic rw_mem,
                                 input logic [4:0] wr_mem, input logic br);
        stim_t s;
        s.rst = 1'b1; s.rs = rs; s.rt = rt; s.use_rt = use_rt; s.pcsrc = pcsrc;
        s.rw_ex = rw_ex; s.mr_ex = mr_ex; s.wr_ex = wr_ex;
        s.rw_mem = rw_mem; s.wr_mem = wr_mem; s.br = br;
        return s;
    endfunction

    function automatic stim_t idle();
        return st(5'd0, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endfunction

    // Drive one cycle of stimulus 1 time unit after the rising edge, queue its expectation,
    // and leave the caller 3 time units after the edge to sample.
    task automatic step(input stim_t s, input logic [3:0] e);
        @(posedge clk);
        #1;
        reset              = s.rst;
        Rs                 = s.rs;
        Rt                 = s.rt;
        UseRt              = s.use_rt;
        PCSrc              = s.pcsrc;
        RegWrite_ex        = s.rw_ex;
        MemRead_ex         = s.mr_ex;
        Write_register     = s.wr_ex;
        RegWrite_mem       = s.rw_mem;
        Write_register_mem = s.wr_mem;
        BranchTaken_ex     = s.br;
        exp_q.push_back(e);
        #2;
    endtask

    task automatic test_reset();
        logic [3:0] got, e;
        stim_t s;
        s = idle();
        s.rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(s, E_RST);
            got = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset cyc%0d got=%b exp=%b", i, got, e);
            end
        end
        step(idle(), E_RUN);
        got = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", got, e);
        end
    endtask

    // lw $t0 in EX, add $t1,$t0,$t2 in ID; then Rt-path with and without UseRt
    task automatic test_load_use();
        stim_t      rows[6];
        logic [3:0] exps[6];
        logic [3:0] got, e;
        rows[0] = st(5'd8, 5'd10, 1'b1, 3'b000, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0); exps[0] = E_STALL;
        rows[1] = st(5'd8, 5'd10, 1'b1, 3'b000, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0); exps[1] = E_RUN;
        rows[2] = st(5'd9, 5'd8,  1'b0, 3'b000, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0); exps[2] = E_RUN;
        rows[3] = st(5'd9, 5'd8,  1'b1, 3'b000, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0); exps[3] = E_STALL;
        rows[4] = st(5'd9, 5'd8,  1'b1, 3'b000, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0); exps[4] = E_RUN;
        rows[5] = st(5'd9, 5'd10, 1'b1, 3'b000, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0); exps[5] = E_RUN;
        for (int i = 0; i < 6; i++) begin
            step(rows[i], exps[i]);
            got = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL load_use row%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

    // lw $t0 in EX, jr $t0 in ID: two stalls then PC resumes
    task automatic test_jr_ex_load();
        stim_t      rows[3];
        logic [3:0] exps[3];
        logic [3:0] got, e;
        rows[0] = st(5'd8, 5'd0, 1'b0, 3'b011, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0); exps[0] = E_STALL;
        rows[1] = st(5'd8, 5'd0, 1'b0, 3'b011, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0); exps[1] = E_STALL;
        rows[2] = st(5'd8, 5'd0, 1'b0, 3'b011, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); exps[2] = E_RUN;
        for (int i = 0; i < 3; i++) begin
            step(rows[i], exps[i]);
            got = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL jr_ex_load cyc%0d got=%b exp=%b", i + 1, got, e);
            end
        end
    endtask

    // addi $ra in EX (forwarded) vs in MEM (one stall); non-jr and $0 in MEM never stall
    task automatic test_jr_forward_mem();
        stim_t      rows[5];
        logic [3:0] exps[5];
        logic [3:0] got, e;
        rows[0] = st(5'd31, 5'd0, 1'b0, 3'b011, 1'b1, 1'b0, 5'd31, 1'b0, 5'd0,  1'b0); exps[0] = E_RUN;
        rows[1] = st(5'd31, 5'd0, 1'b0, 3'b011, 1'b0, 1'b0, 5'd0,  1'b1, 5'd31, 1'b0); exps[1] = E_STALL;
        rows[2] = st(5'd31, 5'd0, 1'b0, 3'b011, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0); exps[2] = E_RUN;
        rows[3] = st(5'd31, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0,  1'b1, 5'd31, 1'b0); exps[3] = E_RUN;
        rows[4] = st(5'd0,  5'd0, 1'b0, 3'b011, 1'b0, 1'b0, 5'd0,  1'b1, 5'd0,  1'b0); exps[4] = E_RUN;
        for (int i = 0; i < 5; i++) begin
            step(rows[i], exps[i]);
            got = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL jr_fwd_mem row%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

    // Load to $0 never creates a dependency, even for jr
    task automatic test_zero_reg();
        stim_t      rows[2];
        logic [3:0] exps[2];
        logic [3:0] got, e;
        rows[0] = st(5'd0, 5'd0, 1'b1, 3'b000, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); exps[0] = E_RUN;
        rows[1] = st(5'd0, 5'd0, 1'b0, 3'b011, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); exps[1] = E_RUN;
        for (int i = 0; i < 2; i++) begin
            step(rows[i], exps[i]);
            got = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL zero_reg row%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

    // Branch aborts HOLD1 and returns to RUN; branch also overrides a RUN hazard
    task automatic test_branch_flush();
        stim_t      rows[5];
        logic [3:0] exps[5];
        logic [3:0] got, e;
        rows[0] = st(5'd8, 5'd0, 1'b0, 3'b011, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0); exps[0] = E_STALL;
        rows[1] = st(5'd8, 5'd0, 1'b0, 3'b011, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1); exps[1] = E_FLUSH;
        rows[2] = idle();                                                            exps[2] = E_RUN;
        rows[3] = st(5'd8, 5'd0, 1'b0, 3'b011, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b1); exps[3] = E_FLUSH;
        rows[4] = idle();                                                            exps[4] = E_RUN;
        for (int i = 0; i < 5; i++) begin
            step(rows[i], exps[i]);
            got = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL branch_flush row%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

    // After a 2-cycle hold the next RUN cycle re-evaluates a fresh load-use
    task automatic test_back_to_back();
        stim_t      rows[5];
        logic [3:0] exps[5];
        logic [3:0] got, e;
        rows[0] = st(5'd8,  5'd0, 1'b0, 3'b011, 1'b1, 1'b1, 5'd8,  1'b0, 5'd0, 1'b0); exps[0] = E_STALL;
        rows[1] = st(5'd8,  5'd0, 1'b0, 3'b011, 1'b0, 1'b0, 5'd0,  1'b1, 5'd8, 1'b0); exps[1] = E_STALL;
        rows[2] = st(5'd12, 5'd0, 1'b0, 3'b000, 1'b1, 1'b1, 5'd12, 1'b0, 5'd0, 1'b0); exps[2] = E_STALL;
        rows[3] = st(5'd12, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0,  1'b1, 5'd12, 1'b0); exps[3] = E_RUN;
        rows[4] = idle();                                                              exps[4] = E_RUN;
        for (int i = 0; i < 5; i++) begin
            step(rows[i], exps[i]);
            got = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL back_to_back row%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

    // Reset during HOLD1 forces reset outputs and leaves the FSM in RUN on release
    task automatic test_reset_mid_hold();
        stim_t      rows[3];
        logic [3:0] exps[3];
        logic [3:0] got, e;
        rows[0] = st(5'd8, 5'd0, 1'b0, 3'b011, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0); exps[0] = E_STALL;
        rows[1] = st(5'd8, 5'd0, 1'b0, 3'b011, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
        rows[1].rst = 1'b0;                                                          exps[1] = E_RST;
        rows[2] = idle();                                                            exps[2] = E_RUN;
        for (int i = 0; i < 3; i++) begin
            step(rows[i], exps[i]);
            got = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_mid_hold row%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

`ifdef HAZARD_STATS_EN
    // 3 stall cycles + 1 flush cycle after a clean reset, then reset mid-hold clears counters
    task automatic test_stats();
        stim_t      rows[7];
        logic [3:0] exps[7];
        logic [3:0] got, e;
        stim_t      s;
        s = idle();
        s.rst = 1'b0;
        step(s, E_RST);
        void'(exp_q.pop_front());
        rows[0] = st(5'd8, 5'd0, 1'b0, 3'b000, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0); exps[0] = E_STALL;
        rows[1] = idle();                                                            exps[1] = E_RUN;
        rows[2] = st(5'd8, 5'd0, 1'b0, 3'b011, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0); exps[2] = E_STALL;
        rows[3] = idle();                                                            exps[3] = E_STALL;
        rows[4] = idle();                                                            exps[4] = E_RUN;
        rows[5] = st(5'd0, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1); exps[5] = E_FLUSH;
        rows[6] = idle();                                                            exps[6] = E_RUN;
        for (int i = 0; i < 7; i++) begin
            step(rows[i], exps[i]);
            got = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL stats_seq row%0d got=%b exp=%b", i, got, e);
            end
        end
        checks++;
        if (StallCycles !== STAT_W'(3)) begin
            errors++;
            $display("FAIL stall_count got=%0d exp=3", StallCycles);
        end
        checks++;
        if (FlushCount !== STAT_W'(1)) begin
            errors++;
            $display("FAIL flush_count got=%0d exp=1", FlushCount);
        end
        step(st(5'd8, 5'd0, 1'b0, 3'b011, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0), E_STALL);
        void'(exp_q.pop_front());
        s = idle();
        s.rst = 1'b0;
        step(s, E_RST);
        got = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush};
        e = exp_q.pop_front();
        checks++;
        if (got !== e || StallCycles !== '0 || FlushCount !== '0) begin
            errors++;
            $display("FAIL stats_reset got=%b/%0d/%0d exp=%b/0/0", got, StallCycles, FlushCount, e);
        end
        step(idle(), E_RUN);
        void'(exp_q.pop_front());
    endtask
`endif

    initial begin
        reset = 1'b0; Rs = '0; Rt = '0; UseRt = 1'b0; PCSrc = '0;
        RegWrite_ex = 1'b0; MemRead_ex = 1'b0; Write_register = '0;
        RegWrite_mem = 1'b0; Write_register_mem = '0; BranchTaken_ex = 1'b0;
        test_reset();
        test_load_use();
        test_jr_ex_load();
        test_jr_forward_mem();
        test_zero_reg();
        test_branch_flush();
        test_back_to_back();
        test_reset_mid_hold();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
